bcd_counter_ndig: RTL

//  Parametrised N-digit BCD counter; successor to the fixed 3-digit hundreds/tens/units counter.

---
 rtl/bcd_pkg.sv | 28 ++
 rtl/bcd_counter_ndig_digit.sv | 47 ++++
 rtl/bcd_counter_ndig.sv | 99 +++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD digit types, limits and step helpers.
// Used by the digit register and the N-digit counter top.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    typedef logic [3:0] bcd_t;

    function automatic logic bcd_valid(input bcd_t d);
        return d <= BCD_MAX;
    endfunction

    // Returns {carry, next}; carry means the digit sat at its limit
    // for this direction and rolled over to the opposite limit.
    function automatic logic [4:0] bcd_step(input bcd_t d, input logic up);
        logic [4:0] r;
        if (up) begin
            if (d >= BCD_MAX) r = {1'b1, BCD_MIN};
            else              r = {1'b0, d + 4'd1};
        end else begin
            if (d == BCD_MIN) r = {1'b1, BCD_MAX};
            else              r = {1'b0, d - 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_counter_ndig_digit.sv
// One BCD digit register: forced value, single step, or hold.
// Reports its limits and the carry/borrow for the ripple chain.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic set_en,
    input  bcd_t set_val,
    input  logic step_en,
    input  logic up,
    output bcd_t digit,
    output logic at_max,
    output logic at_min,
    output logic carry
);

    bcd_t       digit_q;
    bcd_t       digit_d;
    logic [4:0] step_r;

    // Next digit: a forced value beats stepping; otherwise hold
    always_comb begin
        step_r  = bcd_step(digit_q, up);
        digit_d = digit_q;
        if (set_en) begin
            digit_d = set_val;
        end else if (step_en) begin
            digit_d = step_r[3:0];
        end
    end

    // Digit register, cleared immediately by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_q <= BCD_MIN;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit  = digit_q;
    assign at_max = (digit_q == BCD_MAX);
    assign at_min = (digit_q == BCD_MIN);
    assign carry  = step_r[4];

endmodule

// File: rtl/bcd_counter_ndig.sv
// N-digit up/down BCD counter with clear, load, saturate/wrap,
// combinational terminal count and registered wrap/load-error pulses.
module bcd_counter_ndig
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 3,
    parameter int SATURATE = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                up_dn,
    input  logic                clr,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] count,
    output logic                tc,
    output logic                wrapped,
    output logic                load_err
);

    logic [DIGITS-1:0]   at_max;
    logic [DIGITS-1:0]   at_min;
    logic [DIGITS-1:0]   carry;
    logic [DIGITS-1:0]   step_en;
    logic [4*DIGITS-1:0] set_val;
    logic                set_en;
    logic                bad_load;
    logic                at_limit;
    logic                step_ok;
    logic                ripple;
    logic                wrapped_q;
    logic                wrapped_d;
    logic                load_err_q;
    logic                load_err_d;

    // Clear/load value: invalid load digits become 0 and flag an error
    always_comb begin
        set_en   = clr | load;
        set_val  = '0;
        bad_load = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (!bcd_valid(load_val[4*k +: 4])) begin
                bad_load = 1'b1;
            end else if (!clr) begin
                set_val[4*k +: 4] = load_val[4*k +: 4];
            end
        end
    end

    // Limit detect, saturate gate and ripple-enable chain
    always_comb begin
        at_limit = up_dn ? (&at_max) : (&at_min);
        step_ok  = en & ~((SATURATE != 0) & at_limit);
        ripple   = step_ok;
        step_en  = '0;
        for (int k = 0; k < DIGITS; k++) begin
            step_en[k] = ripple;
            ripple     = ripple & carry[k];
        end
    end

    // Pulse flags: set for one cycle after a wrap or a bad load
    always_comb begin
        wrapped_d  = (SATURATE == 0) & en & at_limit & ~clr & ~load;
        load_err_d = ~clr & load & bad_load;
    end

    // Pulse flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrapped_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            wrapped_q  <= wrapped_d;
            load_err_q <= load_err_d;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_digit u_digit (
            .clk     (clk),
            .rst     (rst),
            .set_en  (set_en),
            .set_val (set_val[4*g +: 4]),
            .step_en (step_en[g]),
            .up      (up_dn),
            .digit   (count[4*g +: 4]),
            .at_max  (at_max[g]),
            .at_min  (at_min[g]),
            .carry   (carry[g])
        );
    end

    assign tc       = en & at_limit;
    assign wrapped  = wrapped_q;
    assign load_err = load_err_q;

endmodule
